// File: rtl/ps2_key_event_queue_if.sv
// Key-event bus between the PS/2 scancode source, the event queue and one consumer.
// Handshake: an event moves on a rising clk edge where evt_valid && evt_ready; evt_* hold steady while evt_valid && !evt_ready.
interface ps2_key_event_queue_if #(
  parameter int PTR_W = 3
);
  logic             code_valid;
  logic [7:0]       code;
  logic             evt_valid;
  logic             evt_ready;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic [PTR_W:0]   evt_count;
  logic             overflow;
  logic             clear_overflow;

  modport master (
    output code_valid, code, evt_ready, clear_overflow,
    input  evt_valid, evt_code, evt_ext, evt_break, evt_count, overflow
  );

  modport slave (
    input  code_valid, code, evt_ready, clear_overflow,
    output evt_valid, evt_code, evt_ext, evt_break, evt_count, overflow
  );
endinterface

// File: rtl/ps2_key_event_queue.sv
// Resolves E0/F0 scancode prefixes into key events and queues them in a show-ahead FIFO
// for a single valid/ready consumer.
module ps2_key_event_queue #(
  parameter int DEPTH       = 8,
  parameter int PTR_W       = 3,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ps2_key_event_queue_if.slave bus,
  output logic [1:0]           fsm_state
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRE_E0   = 2'd1,
    PRE_F0   = 2'd2,
    PRE_E0F0 = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             discard;
  logic             push, pop, full, do_push, drop;
  logic             evt_ext_new, evt_break_new;

  logic [9:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [9:0]       head_hold;
  logic [9:0]       head;

  assign fsm_state = state;
  assign discard   = (bus.code == 8'h00) || (bus.code == 8'hFF) || (bus.code == 8'hAA) ||
                     (bus.code == 8'hFA) || (bus.code == 8'hFE) || (bus.code == 8'hE1);
  assign tmo_hit   = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A byte arriving in the expiry cycle takes priority, so it sees the pre-timeout state.
  always_comb begin
    state_next    = state;
    push          = 1'b0;
    evt_ext_new   = (state == PRE_E0) || (state == PRE_E0F0);
    evt_break_new = (state == PRE_F0) || (state == PRE_E0F0);
    if (bus.code_valid) begin
      if (discard) begin
        state_next = IDLE;
      end else if (bus.code == 8'hE0) begin
        case (state)
          IDLE:    state_next = PRE_E0;
          PRE_F0:  state_next = PRE_E0F0;
          default: state_next = state;
        endcase
      end else if (bus.code == 8'hF0) begin
        case (state)
          IDLE:    state_next = PRE_F0;
          PRE_E0:  state_next = PRE_E0F0;
          default: state_next = state;
        endcase
      end else begin
        push       = 1'b1;
        state_next = IDLE;
      end
    end else if (tmo_hit) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                         tmo_cnt <= '0;
    else if (bus.code_valid || state == IDLE || tmo_hit)  tmo_cnt <= '0;
    else                                                  tmo_cnt <= tmo_cnt + 1'b1;
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign pop     = bus.evt_ready && (count != '0);
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {evt_break_new, evt_ext_new, bus.code};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_hold <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (count != '0) head_hold <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                bus.overflow <= 1'b0;
    else if (drop)               bus.overflow <= 1'b1;
    else if (bus.clear_overflow) bus.overflow <= 1'b0;
  end

  // While empty the outputs freeze on the last head shown.
  assign head          = (count != '0) ? mem[rd_ptr] : head_hold;
  assign bus.evt_valid = (count != '0);
  assign bus.evt_count = count;
  assign bus.evt_code  = head[7:0];
  assign bus.evt_ext   = head[8];
  assign bus.evt_break = head[9];
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench for ps2_key_event_queue: expected events are queued by hand and
// matched against every consumer handshake.
module tb_ps2_key_event_queue;
  localparam int DEPTH       = 8;
  localparam int PTR_W       = 3;
  localparam int TIMEOUT_CYC = 64;

  logic       clk;
  logic       reset_n;
  logic [1:0] fsm_state;
  int         total = 0;
  int         bad   = 0;
  logic [9:0] exp_q[$];

  ps2_key_event_queue_if #(.PTR_W(PTR_W)) bus ();

  ps2_key_event_queue #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] ev(input logic brk, input logic ext, input logic [7:0] c);
    return {brk, ext, c};
  endfunction

  // driver tasks
  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    @(posedge clk);
    #1 bus.code_valid = 1'b1;
    bus.code = b;
    @(posedge clk);
    #1 bus.code_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (bus.evt_count != '0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1 check("drain_count", 32'(bus.evt_count), 0);
  endtask

  // scoreboard: compare each accepted event against the expected queue
  always @(negedge clk) begin
    if (reset_n && bus.evt_valid && bus.evt_ready) begin
      check("sb_has_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        check("evt", 32'({bus.evt_break, bus.evt_ext, bus.evt_code}), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    reset_n            = 1'b0;
    bus.code_valid     = 1'b0;
    bus.code           = 8'h00;
    bus.evt_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.evt_valid), 0);
    check("rst_count", 32'(bus.evt_count), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_code", 32'(bus.evt_code), 0);
    check("rst_ext", 32'(bus.evt_ext), 0);
    check("rst_brk", 32'(bus.evt_break), 0);
    check("rst_state", 32'(fsm_state), 0);
    @(negedge clk) reset_n = 1'b1;

    // make / break, one-cycle latency
    bus.evt_ready = 1'b1;
    exp_q.push_back(ev(0, 0, 8'h1C));
    send(8'h1C);
    check("make_latency", 32'(bus.evt_valid), 1);
    repeat (1000) @(posedge clk);
    exp_q.push_back(ev(1, 0, 8'h1C));
    send(8'hF0);
    send(8'h1C);
    check("break_latency", 32'(bus.evt_valid), 1);

    // extended make, extended break in both prefix orders
    exp_q.push_back(ev(0, 1, 8'h75));
    send(8'hE0); send(8'h75);
    exp_q.push_back(ev(1, 1, 8'h75));
    send(8'hE0); send(8'hF0); send(8'h75);
    exp_q.push_back(ev(1, 1, 8'h75));
    send(8'hF0); send(8'hE0); send(8'h75);

    // prefix timeout: still pending one cycle before expiry, IDLE right after
    send(8'hE0);
    check("tmo_pending", 32'(fsm_state), 1);
    repeat (TIMEOUT_CYC - 1) @(posedge clk);
    #1 check("tmo_before", 32'(fsm_state), 1);
    @(posedge clk);
    #1 check("tmo_expired", 32'(fsm_state), 0);
    repeat (5) @(posedge clk);
    exp_q.push_back(ev(0, 0, 8'h1D));
    send(8'h1D);

    // discard bytes cancel prefixes and never produce events
    exp_q.push_back(ev(0, 0, 8'h1D));
    send(8'hF0); send(8'hFA); send(8'h1D);
    send(8'hAA);
    repeat (5) @(posedge clk);
    #1 check("discard_count", 32'(bus.evt_count), 0);

    // overflow: nine makes into eight slots, last one dropped
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(ev(0, 0, 8'(8'h15 + i)));
      send(8'(8'h15 + i));
    end
    @(posedge clk);
    #1;
    check("ovf_count", 32'(bus.evt_count), 8);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_head", 32'(bus.evt_code), 32'h15);
    bus.evt_ready = 1'b1;
    wait_empty(50);
    check("ovf_sticky", 32'(bus.overflow), 1);
    bus.clear_overflow = 1'b1;
    @(posedge clk);
    #1 bus.clear_overflow = 1'b0;
    check("ovf_cleared", 32'(bus.overflow), 0);

    // full with simultaneous push and pop
    bus.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ev(0, 0, 8'(8'h20 + i)));
      send(8'(8'h20 + i));
    end
    exp_q.push_back(ev(0, 0, 8'h2A));
    @(posedge clk);
    #1 check("full_count", 32'(bus.evt_count), 8);
    bus.code_valid = 1'b1;
    bus.code       = 8'h2A;
    bus.evt_ready  = 1'b1;
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    bus.evt_ready  = 1'b0;
    check("pushpop_count", 32'(bus.evt_count), 8);
    check("pushpop_ovf", 32'(bus.overflow), 0);
    bus.evt_ready = 1'b1;
    wait_empty(50);

    // async reset with queued events and a pending prefix
    bus.evt_ready = 1'b0;
    send(8'h31); send(8'h32); send(8'h33);
    send(8'hE0);
    @(posedge clk);
    #1 check("pre_rst_count", 32'(bus.evt_count), 3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.evt_valid), 0);
    check("arst_count", 32'(bus.evt_count), 0);
    check("arst_code", 32'(bus.evt_code), 0);
    check("arst_state", 32'(fsm_state), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    bus.evt_ready = 1'b1;
    exp_q.push_back(ev(0, 0, 8'h1C));
    send(8'h1C);
    check("post_rst_valid", 32'(bus.evt_valid), 1);
    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 0);
    check("final_count", 32'(bus.evt_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
